// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state encoding and default burst/weight sizing for conv_row_scheduler.
`timescale 1ns/1ps
`default_nettype none

package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WLOAD    = 3'd1,
    WAIT_ROW = 3'd2,
    BURST    = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Smallest multiple of y that is >= x.
  function automatic int ceil_mul(input int x, input int y);
    return ((x + y - 1) / y) * y;
  endfunction

  localparam int DEF_N    = 5;
  localparam int DEF_HOUT = 44;
  localparam int DEF_WH   = 3;
  localparam int DEF_IW   = 2;
  localparam int DEF_WW   = 11;
  localparam int DEF_K    = 3;

  localparam int DEF_NEXT_N_UP    = ceil_mul(DEF_N, DEF_WH * DEF_IW);
  localparam int DEF_BURST_LEN    = DEF_NEXT_N_UP * DEF_HOUT / (DEF_WH * DEF_IW);
  localparam int DEF_WEIGHT_WORDS = DEF_K * DEF_K * DEF_WW * DEF_WH;

endpackage

`default_nettype wire

// File: rtl/sched_down_counter.sv
// sched_down_counter: loadable down-counter with synchronous clear and a zero flag.
`timescale 1ns/1ps
`default_nettype none

module sched_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: weight preload, then fixed-length row-read bursts into the PE array.
// Define SCHED_STALL_EN to pause a burst while any row FIFO reports prog_empty.
`timescale 1ns/1ps
`default_nettype none

module conv_row_scheduler
  import conv_sched_pkg::*;
#(
  parameter int WH           = 3,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int WEIGHT_WORDS = DEF_WEIGHT_WORDS,
  parameter int ROWS         = 25,
  parameter int GAP          = 2,
  parameter int ROW_WIDTH    = 10,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 weight_wr_i,
  input  logic [WH-1:0]        prog_empty_i,
  output logic [WH-1:0]        fifo_rden_o,
  output logic                 pe_ready_o,
  output logic [ROW_WIDTH-1:0] row_cnt_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [CNT_WIDTH-1:0] BURST_LOAD  = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD    = CNT_WIDTH'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] WEIGHT_LAST = CNT_WIDTH'(WEIGHT_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] WEIGHT_FULL = CNT_WIDTH'(WEIGHT_WORDS);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST    = ROW_WIDTH'(ROWS - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [ROW_WIDTH-1:0]   row_q, row_d;
  logic                   rden_q, rden_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   data_valid;
  logic                   burst_load, burst_dec, burst_zero;
  logic                   gap_load, gap_dec, gap_zero;

  assign data_valid = ~(|prog_empty_i);

  // Burst counter holds the reads still to be scheduled after the current one.
  sched_down_counter #(.WIDTH(CNT_WIDTH)) u_burst_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (abort_i),
    .load_i     (burst_load),
    .load_val_i (BURST_LOAD),
    .dec_i      (burst_dec),
    .zero_o     (burst_zero)
  );

  sched_down_counter #(.WIDTH(CNT_WIDTH)) u_gap_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (abort_i),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    row_d      = row_q;
    rden_d     = 1'b0;
    done_d     = 1'b0;
    burst_load = 1'b0;
    burst_dec  = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WLOAD;
          row_d   = '0;
          wcnt_d  = '0;
        end
      end
      WLOAD: begin
        if (weight_wr_i) begin
          wcnt_d = (wcnt_q == WEIGHT_FULL) ? wcnt_q : wcnt_q + 1'b1;
          if (wcnt_q == WEIGHT_LAST) begin
            state_d = WAIT_ROW;
          end
        end
      end
      WAIT_ROW: begin
        if (data_valid) begin
          state_d    = BURST;
          rden_d     = 1'b1;
          burst_load = 1'b1;
        end
      end
      BURST: begin
        if (burst_zero) begin
          row_d = row_q + 1'b1;
          if (row_q == ROW_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (GAP == 0) begin
            state_d = WAIT_ROW;
          end else begin
            state_d  = conv_sched_pkg::GAP;
            gap_load = 1'b1;
          end
        end else begin
`ifdef SCHED_STALL_EN
          rden_d = data_valid;
`else
          rden_d = 1'b1;
`endif
          burst_dec = rden_d;
        end
      end
      conv_sched_pkg::GAP: begin
        // The last gap cycle doubles as the valid-sampling cycle, so the
        // idle stretch between bursts is exactly GAP cycles when data is ready.
        if (gap_zero) begin
          if (data_valid) begin
            state_d    = BURST;
            rden_d     = 1'b1;
            burst_load = 1'b1;
          end else begin
            state_d = WAIT_ROW;
          end
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      state_d    = IDLE;
      wcnt_d     = '0;
      row_d      = '0;
      rden_d     = 1'b0;
      done_d     = 1'b0;
      burst_load = 1'b0;
      burst_dec  = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      row_q   <= '0;
      rden_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      row_q   <= row_d;
      rden_q  <= rden_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_rden_o = {WH{rden_q}};
  assign pe_ready_o  = rden_q;
  assign row_cnt_o   = row_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_row_scheduler.sv
// tb_conv_row_scheduler: directed table plus multi-cycle sequences for conv_row_scheduler.
`timescale 1ns/1ps
`default_nettype none

module tb_conv_row_scheduler;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       abort;
  logic       wr;
  logic [2:0] pe;
  logic [2:0] rden;
  logic       pe_ready;
  logic [9:0] row;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

`ifdef SCHED_STALL_EN
  localparam int EXP_SPAN = 49;
`else
  localparam int EXP_SPAN = 44;
`endif

  conv_row_scheduler dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (start),
    .abort_i      (abort),
    .weight_wr_i  (wr),
    .prog_empty_i (pe),
    .fifo_rden_o  (rden),
    .pe_ready_o   (pe_ready),
    .row_cnt_o    (row),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cycles;
    logic       start;
    logic       abort;
    logic       wr;
    logic [2:0] pe;
    logic       rden;
    logic       busy;
    logic       done;
    int         row;
    string      name;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    wr    = 1'b1;
    repeat (297) tick();
    wr = 1'b0;
    chk("wait_row_no_rden", int'(pe_ready), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int er_bad, row_bad, done_bad, busy_bad, bad, k, reads, span;
    logic er;
    int erow;

    vecs[0]  = '{1,   1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, "reset_state"};
    vecs[1]  = '{1,   1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, "wr_in_idle"};
    vecs[2]  = '{1,   1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0, "start"};
    vecs[3]  = '{296, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 0, "wr_296"};
    vecs[4]  = '{3,   1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0, "hold_296"};
    vecs[5]  = '{1,   1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 0, "wr_297"};
    vecs[6]  = '{10,  1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 0, "valid_gate"};
    vecs[7]  = '{1,   1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 0, "valid_rise"};
    vecs[8]  = '{43,  1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 0, "burst_last"};
    vecs[9]  = '{1,   1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1, "burst_end"};
    vecs[10] = '{1,   1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, "abort_gap"};
    vecs[11] = '{5,   1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, "idle_after"};

    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    wr    = 1'b0;
    pe    = 3'b000;
    repeat (3) tick();
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      wr    = vecs[i].wr;
      pe    = vecs[i].pe;
      repeat (vecs[i].cycles) tick();
      chk({vecs[i].name, "_rden"}, int'(rden), vecs[i].rden ? 7 : 0);
      chk({vecs[i].name, "_busy"}, int'(busy), int'(vecs[i].busy));
      chk({vecs[i].name, "_done"}, int'(done), int'(vecs[i].done));
      chk({vecs[i].name, "_row"}, int'(row), vecs[i].row);
    end
    start = 1'b0;
    abort = 1'b0;
    wr    = 1'b0;
    pe    = 3'b000;

    // Full pass: bursts of 44 reads separated by 2 idle cycles, done after the 25th.
    load_pass();
    er_bad = 0; row_bad = 0; done_bad = 0; busy_bad = 0;
    for (int c = 0; c < 1152; c++) begin
      tick();
      er   = (c < 1148) && ((c % 46) < 44);
      erow = ((c + 2) / 46 > 25) ? 25 : (c + 2) / 46;
      if (rden !== {3{er}} || pe_ready !== er) er_bad++;
      if (int'(row) != erow) row_bad++;
      if (done !== (c == 1148)) done_bad++;
      if (busy !== (c <= 1148)) busy_bad++;
      if (c == 0) chk("first_rden", int'(pe_ready), 1);
    end
    chk("pass_rden_errs", er_bad, 0);
    chk("pass_row_errs", row_bad, 0);
    chk("pass_done_errs", done_bad, 0);
    chk("pass_busy_errs", busy_bad, 0);
    chk("pass_final_row", int'(row), 25);

    // Abort together with start during the burst of row 7.
    load_pass();
    for (k = 0; k < 2000 && !(row == 10'd7 && pe_ready); k++) tick();
    chk("reach_row7", int'(k < 2000), 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort7_rden", int'(rden), 0);
    chk("abort7_busy", int'(busy), 0);
    chk("abort7_row", int'(row), 0);
    chk("abort7_done", int'(done), 0);
    bad = 0;
    repeat (60) begin
      tick();
      if (pe_ready || done || busy) bad++;
    end
    chk("abort7_stays_idle", bad, 0);

    // Empty FIFO for 5 cycles in the middle of burst 0.
    load_pass();
    tick();
    reads = 0;
    span  = -1;
    for (int c = 0; c < 200; c++) begin
      if (row == 10'd0 && pe_ready) reads++;
      if (row == 10'd1) begin
        span = c;
        break;
      end
      pe = (c >= 10 && c < 15) ? 3'b100 : 3'b000;
      tick();
    end
    pe = 3'b000;
    chk("stall_reads", reads, 44);
    chk("stall_span", span, EXP_SPAN);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset in the middle of a burst.
    load_pass();
    repeat (100) tick();
    chk("pre_rst_row", int'(row), 2);
    chk("pre_rst_rden", int'(pe_ready), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_rden", int'(rden), 0);
    chk("rst_pe_ready", int'(pe_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_row", int'(row), 0);
    #1;
    rstn = 1'b1;
    tick();
    repeat (5) tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_rden", int'(pe_ready), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", int'(busy), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
